// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: loader states,
// word geometry and the rule that turns a requested word count into the
// number of words actually loaded.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int IMEM_DEPTH     = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

    // A count of zero, or one larger than the RAM, means "fill the whole RAM".
    function automatic int effectiveCount(input int wc, input int depth);
        if (wc == 0 || wc > depth) begin
            return depth;
        end
        return wc;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, RAM write port and CPU control outputs of the
// instruction-memory loader, bundled so the loader and its driver share one
// declaration. The master side feeds bytes and starts loads; the slave side
// is the loader itself.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int CNT_W = 11
);

    logic              start;
    logic [CNT_W-1:0]  word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done
    );

endinterface

// File: rtl/imem_word_packer.sv
// Packs a byte stream into 32-bit words, most significant byte first.
// word_full flags the shift that completes a word so the controller can move
// to its write cycle on the same edge the fourth byte lands.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [WORD_W-1:0] r_shift;
    logic [1:0]        r_byteCnt;

    // Shift each accepted byte in at the bottom; the counter wraps every word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_shift   <= '0;
            r_byteCnt <= '0;
        end else if (shift_en) begin
            r_shift   <= {r_shift[WORD_W-9:0], byte_in};
            r_byteCnt <= r_byteCnt + 2'd1;
        end
    end

    assign word      = r_shift;
    assign word_full = shift_en && (r_byteCnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction RAM. Collects a byte stream into words,
// writes them at consecutive word addresses from 0 and holds the CPU in
// reset until the whole program is in place.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 11
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    loader_state_t     r_state;
    loader_state_t     w_nextState;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_wordIdx;
    logic [WORD_W-1:0] r_memAddr;
    logic [WORD_W-1:0] r_memWdata;

    logic              w_startOk;
    logic              w_accept;
    logic              w_wordFull;
    logic              w_lastWord;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_liveAddr;
    logic              w_byteReady;
    logic              w_memWe;
    logic              w_busy;
    logic              w_done;

    assign w_startOk  = (r_state == IDLE) && bus.start;
    assign w_accept   = bus.byte_valid && w_byteReady;
    assign w_lastWord = (r_wordIdx == r_n - CNT_W'(1));
    assign w_liveAddr = {{(WORD_W - 2 - CNT_W){1'b0}}, r_wordIdx, 2'b00};

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_startOk),
        .shift_en  (w_accept),
        .byte_in   (bus.byte_data),
        .word      (w_word),
        .word_full (w_wordFull)
    );

    // State register; reset always wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: collect four bytes, spend one cycle writing, repeat until the last word.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_nextState = RECV;
            RECV:    if (w_wordFull) w_nextState = WRITE;
            WRITE:   w_nextState = w_lastWord ? DONE : RECV;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Control outputs decoded from the state; the CPU is held for the whole load.
    always_comb begin
        w_byteReady = 1'b0;
        w_memWe     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            RECV: begin
                w_byteReady = 1'b1;
                w_busy      = 1'b1;
            end
            WRITE: begin
                w_memWe = 1'b1;
                w_busy  = 1'b1;
            end
            DONE: begin
                w_done = 1'b1;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Load length and word index: latched on an accepted start, advanced once per write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n       <= '0;
            r_wordIdx <= '0;
        end else if (w_startOk) begin
            r_n       <= CNT_W'(effectiveCount(32'(bus.word_count), DEPTH));
            r_wordIdx <= '0;
        end else if (r_state == WRITE) begin
            r_wordIdx <= r_wordIdx + CNT_W'(1);
        end
    end

    // Keep a copy of the last write so address and data hold after the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else if (r_state == WRITE) begin
            r_memAddr  <= w_liveAddr;
            r_memWdata <= w_word;
        end
    end

    assign bus.byte_ready = w_byteReady;
    assign bus.mem_we     = w_memWe;
    assign bus.mem_addr   = w_memWe ? w_liveAddr : r_memAddr;
    assign bus.mem_wdata  = w_memWe ? w_word : r_memWdata;
    assign bus.cpu_hold   = w_busy;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte gaps, a behavioural
// load model compared every cycle, and literal checks on the RAM image.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if #(.CNT_W(11)) bus ();

    imem_loader #(.DEPTH(DEPTH), .CNT_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Observed RAM image and write log
    logic [31:0] benchMem [0:DEPTH-1];
    logic [31:0] addrLog [$];
    int          writeCount    = 0;
    int          donePulses    = 0;
    int          readyDuringWe = 0;
    logic [31:0] lastAddr      = '0;

    // Behavioural load model
    bit          mValid     = 0;
    bit          mActive    = 0;
    bit          mWriteNow  = 0;
    bit          mDoneNow   = 0;
    bit          mReady     = 0;
    bit          mPrevWrite = 0;
    bit          mPrevDone  = 0;
    int          mN         = 0;
    int          mIdx       = 0;
    int          mBytes     = 0;
    logic [31:0] mWord      = '0;
    logic [31:0] mExpAddr   = '0;
    logic [31:0] mExpData   = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A load is: start, then per word 4 accepted bytes and one write cycle,
    // then one done cycle, then idle again.
    always @(posedge clk) begin
        if (rst) begin
            mValid    = 1;
            mActive   = 0;
            mWriteNow = 0;
            mDoneNow  = 0;
            mBytes    = 0;
            mIdx      = 0;
        end else if (mValid) begin
            mReady     = mActive && !mWriteNow && !mDoneNow;
            mPrevWrite = mWriteNow;
            mPrevDone  = mDoneNow;
            mWriteNow  = 0;
            mDoneNow   = 0;
            if (!mActive) begin
                if (bus.start) begin
                    mActive = 1;
                    mN      = (bus.word_count == 0 || int'(bus.word_count) > DEPTH) ? DEPTH : int'(bus.word_count);
                    mIdx    = 0;
                    mBytes  = 0;
                end
            end else if (mPrevDone) begin
                mActive = 0;
            end else if (mPrevWrite) begin
                mIdx++;
                if (mIdx == mN) mDoneNow = 1;
            end else if (mReady && bus.byte_valid) begin
                mWord = {mWord[23:0], bus.byte_data};
                mBytes++;
                if (mBytes == 4) begin
                    mBytes    = 0;
                    mWriteNow = 1;
                    mExpAddr  = 32'(4 * mIdx);
                    mExpData  = mWord;
                end
            end
        end
    end

    // Compare DUT against the model every cycle and record what the RAM saw.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("ctrl {ready,we,busy,hold,done}",
                        64'({bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_hold, bus.done}),
                        64'({mActive && !mWriteNow && !mDoneNow, mWriteNow, mActive, mActive, mDoneNow}));
            if (mWriteNow) begin
                checkOutput("write addr", 64'(bus.mem_addr), 64'(mExpAddr));
                checkOutput("write data", 64'(bus.mem_wdata), 64'(mExpData));
            end
            if (bus.mem_we === 1'b1) begin
                benchMem[bus.mem_addr[11:2]] = bus.mem_wdata;
                addrLog.push_back(bus.mem_addr);
                lastAddr = bus.mem_addr;
                writeCount++;
                if (bus.byte_ready === 1'b1) readyDuringWe++;
            end
            if (bus.done === 1'b1) donePulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int wc);
        bus.start      = 1'b1;
        bus.word_count = 11'(wc);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit ok;
        bus.byte_valid = 1'b0;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        ok = 0;
        for (int g = 0; g < 100 && !ok; g++) begin
            ok = bus.byte_ready;
            tick();
        end
        bus.byte_valid = 1'b0;
        checkOutput("byte accepted in bound", 64'(ok), 64'(1));
    endtask

    task automatic sendWord(input logic [31:0] w, input int maxGap);
        for (int i = 0; i < 4; i++) begin
            sendByte(w[31 - 8*i -: 8], int'($urandom_range(0, maxGap)));
        end
    endtask

    task automatic waitDone();
        bit ok;
        ok = 0;
        for (int g = 0; g < 200 && !ok; g++) begin
            ok = bus.done;
            if (!ok) tick();
        end
        checkOutput("done within bound", 64'(ok), 64'(1));
    endtask

    initial begin
        logic [31:0] words3 [3];
        logic [31:0] sent [DEPTH];
        int          base;
        int          wcStart;
        int          bad;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;

        // 1: reset values, bytes in IDLE not consumed
        repeat (3) tick();
        checkOutput("reset ctrl", 64'({bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.busy, bus.done}), 64'(0));
        checkOutput("reset addr/data", {bus.mem_addr, bus.mem_wdata}, 64'(0));
        rst = 1'b0;
        repeat (4) tick();
        checkOutput("idle byte_ready", 64'(bus.byte_ready), 64'(0));
        checkOutput("idle no writes", 64'(writeCount), 64'(0));
        bus.byte_valid = 1'b0;
        tick();

        // 2: single word
        applyStimulus(1);
        sendByte(8'h80, 0);
        sendByte(8'h01, 0);
        sendByte(8'h06, 0);
        sendByte(8'h0A, 0);
        waitDone();
        tick();
        checkOutput("single write count", 64'(writeCount), 64'(1));
        checkOutput("single word data", 64'(benchMem[0]), 64'(32'h8001060A));
        checkOutput("single model word", 64'(mExpData), 64'(32'h8001060A));
        checkOutput("single addr", 64'(lastAddr), 64'(0));
        checkOutput("single busy after", 64'(bus.busy), 64'(0));

        // 3: three words with random gaps
        words3[0] = 32'h00000000;
        words3[1] = 32'h8001060A;
        words3[2] = 32'hA800FFFF;
        base = addrLog.size();
        applyStimulus(3);
        for (int i = 0; i < 3; i++) sendWord(words3[i], 3);
        waitDone();
        tick();
        checkOutput("three write count", 64'(addrLog.size() - base), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (base + i < addrLog.size()) checkOutput("three addr order", 64'(addrLog[base + i]), 64'(4 * i));
        end
        checkOutput("three word0", 64'(benchMem[0]), 64'(32'h00000000));
        checkOutput("three word1", 64'(benchMem[1]), 64'(32'h8001060A));
        checkOutput("three word2", 64'(benchMem[2]), 64'(32'hA800FFFF));

        // 4: word_count=0 fills the whole RAM; a mid-load start is ignored
        wcStart = writeCount;
        applyStimulus(0);
        for (int i = 0; i < DEPTH; i++) begin
            sent[i] = $urandom;
            sendWord(sent[i], 0);
            if (i == 100) begin
                bus.start      = 1'b1;
                bus.word_count = 11'd5;
                tick();
                bus.start = 1'b0;
            end
        end
        waitDone();
        tick();
        checkOutput("full load count", 64'(writeCount - wcStart), 64'(DEPTH));
        checkOutput("full load last addr", 64'(lastAddr), 64'(32'hFFC));
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (benchMem[i] !== sent[i]) bad++;
        checkOutput("full load contents", 64'(bad), 64'(0));

        // 5: reset mid-load discards the partial word
        wcStart = writeCount;
        applyStimulus(3);
        sendWord(32'hCAFEF00D, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("rst writes kept at one", 64'(writeCount - wcStart), 64'(1));
        checkOutput("rst busy", 64'(bus.busy), 64'(0));
        checkOutput("rst cpu_hold", 64'(bus.cpu_hold), 64'(0));
        checkOutput("rst word0 kept", 64'(benchMem[0]), 64'(32'hCAFEF00D));
        applyStimulus(1);
        sendWord(32'h12345678, 2);
        waitDone();
        tick();
        checkOutput("reload data", 64'(benchMem[0]), 64'(32'h12345678));
        checkOutput("reload addr", 64'(lastAddr), 64'(0));

        // 6: back-to-back loads
        applyStimulus(2);
        sendWord(32'h01020304, 1);
        sendWord(32'h05060708, 1);
        waitDone();
        tick();
        base = addrLog.size();
        applyStimulus(1);
        checkOutput("b2b start accepted", 64'(bus.busy), 64'(1));
        sendWord(32'hDEADBEEF, 0);
        waitDone();
        tick();
        checkOutput("b2b one write", 64'(addrLog.size() - base), 64'(1));
        if (base < addrLog.size()) checkOutput("b2b restarts at 0", 64'(addrLog[base]), 64'(0));
        checkOutput("b2b data", 64'(benchMem[0]), 64'(32'hDEADBEEF));
        checkOutput("b2b prev word1", 64'(benchMem[1]), 64'(32'h05060708));

        checkOutput("ready during write", 64'(readyDuringWe), 64'(0));
        checkOutput("done pulse total", 64'(donePulses), 64'(6));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
